unsigned8_mul: RTL and testbench
================================

// Module: unsigned8_mul
// PURPOSE
//  Pipelined 8x8 two's-complement multiplier using radix-8 Booth recoding; 16-bit signed product.
//  Despite the legacy name, operands and result are SIGNED.
//  Used as the int8 MAC multiplier in the CNN datapath.
//  iA is weight-stationary: it loads only while iAEn is high; iB streams every cycle.
// PARAMETERS
//  B_NUM  1  number of parallel iB lanes sharing one iA operand (B_NUM >= 1)
// PORTS
//  clk    in   1          rising-edge clock
//  rst    in   1          asynchronous, active-low reset
//  iAEn   in   1          load enable for the iA operand register
//  iA     in   8          signed multiplicand
//  iB     in   8*B_NUM    signed multipliers; lane k = iB[8k+7:8k]
//  oRslt  out  16*B_NUM   signed products; lane k = oRslt[16k+15:16k] = A*B_k
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset rst is asynchronous and active-low.
//  - Reset: every pipeline register clears to 0, so oRslt = 0 during and right after reset.
//  - Stage 1 (edge N):
//     - A register <= iA if iAEn=1, else it holds its value.
//     - B register <= iB unconditionally.
//  - Stage 2 (edge N+1):
//     - 3A = A + 2A, computed at 10 bits.
//     - Booth-recode each B lane into 3 radix-8 digits d0..d2 in -4..+4:
//       d0 from {b2,b1,b0,0}; d1 from {b5,b4,b3,b2}; d2 from {b7,b7,b6,b5}.
//     - Partial products PPi = di*A, sign-extended to 16 bits, shifted by 3i; all registered.
//  - Stage 3 (edge N+2): oRslt lane <= PP0 + PP1 + PP2, truncated to 16 bits; registered output.
//  - Latency: operands sampled at edge N appear on oRslt right after edge N+2.
//     - Throughput: 1 result per cycle; no stalls, no handshake.
//     - With iAEn held high, oRslt(t) = iA(t-3 cycles) * iB(t-3 cycles) in sampled-edge terms.
//  - Range: full signed range, including -128*-128 = +16384 (0x4000) with no overflow.
//  - iAEn low: the A register freezes; new iB values multiply the frozen A.
//     - A change of iAEn affects only results sampled from that edge onward.
//  - Reset mid-stream: all stages clear immediately (asynchronous).
//     - Valid products resume 3 edges after rst is released.
// CONFIGURATION
//  UNSIGNED8_MUL_CHECK_EN defined:
//     - Adds a simulation-only behavioural model: $signed(A)*$signed(B) delayed to match the pipeline.
//     - On any post-reset mismatch with oRslt it issues $error with the operands and both results.
//  UNSIGNED8_MUL_CHECK_EN undefined: no check logic; synthesised netlist is identical.
// STRUCTURE
//  Package unsigned8_mul_pkg:
//     - localparams A_W=8, P_W=16, PP_NUM=3.
//     - typedef booth_digit_t: 3-bit magnitude + neg bit.
//     - typedef pp_t: logic signed [15:0].
//     - Function booth_r8_enc(4-bit window) -> booth_digit_t.
//  Sub-module unsigned8_mul_pp:
//     - One per B lane.
//     - Recodes one B lane and selects/negates 0, A, 2A, 3A or 4A into 3 partial products.
//  Top: A/B input registers, shared 3A adder, B_NUM pp instances, per-lane stage-3 adders.
// TESTING
//  1 Hold rst low 2 cycles with iA=5, iB=7 -> oRslt=0 throughout; release -> 0x0023 three edges later.
//  2 iAEn=1, iA=-127, iB=-127 -> 0x3F01 (16129); iA=127, iB=-127 -> 0xC0FF (-16129).
//  3 Corners: -128*-128 -> 0x4000; -128*127 -> 0xC080; 0*-128 -> 0x0000; 1*-1 -> 0xFFFF.
//  4 Exhaustive sweep of iA and iB over -127..127 (iB inner loop, 1 pair per cycle):
//     - Check every oRslt against the operand product delayed 3 edges; zero mismatches required.
//  5 Load iA=3 (iAEn=1), then iAEn=0 with iA=100, iB=-2..2 -> oRslt -6,-3,0,3,6 (A frozen at 3).
//  6 Assert rst mid-sweep -> oRslt=0 immediately; after release, correct products resume on the 3rd edge.

Source files
------------

// File: rtl/unsigned8_mul_pkg.sv
// Shared widths, Booth digit type and radix-8 recoder for the signed 8x8 multiplier.
package unsigned8_mul_pkg;

    localparam int unsigned A_W    = 8;
    localparam int unsigned P_W    = 16;
    localparam int unsigned PP_NUM = 3;
    localparam int unsigned A3_W   = 10;
    localparam int unsigned WIN_W  = 4;
    localparam int unsigned MAG_W  = 3;

    typedef struct packed {
        logic             neg;
        logic [MAG_W-1:0] mag;
    } booth_digit_t;

    typedef logic signed [P_W-1:0] pp_t;

    // Radix-8 digit of window {x3,x2,x1,x0} = -4*x3 + 2*x2 + x1 + x0, as sign + magnitude
    function automatic booth_digit_t booth_r8_enc(input logic [WIN_W-1:0] win);
        booth_digit_t     d;
        logic [MAG_W-1:0] pos;
        pos   = {1'b0, win[2], 1'b0} + {2'b00, win[1]} + {2'b00, win[0]};
        d.mag = win[3] ? MAG_W'(3'd4 - pos) : pos;
        // 1111 recodes to zero; keep it positive so no negation is applied
        d.neg = win[3] & (pos != 3'd4);
        return d;
    endfunction

endpackage

// File: rtl/unsigned8_mul_pp.sv
// One B lane: radix-8 Booth recode and registered generation of three shifted partial products.
module unsigned8_mul_pp
    import unsigned8_mul_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [A_W-1:0]                a,
    input  logic [A3_W-1:0]               a3,
    input  logic [A_W-1:0]                b,
    output logic [PP_NUM-1:0][P_W-1:0]    pp
);

    // B with an implicit 0 below bit 0 and bit 7 replicated on top
    logic [A_W+1:0]                bx;
    logic [PP_NUM-1:0][P_W-1:0]    pp_c;
    booth_digit_t                  dig;
    pp_t                           sel;

    assign bx = {b[A_W-1], b, 1'b0};

    // Select 0/A/2A/3A/4A at full product width, negate, then weight by 8^i
    always_comb begin
        pp_c = '0;
        dig  = '0;
        sel  = '0;
        for (int unsigned i = 0; i < PP_NUM; i++) begin
            dig = booth_r8_enc(bx[3*i +: WIN_W]);
            case (dig.mag)
                3'd1:    sel = P_W'($signed(a));
                3'd2:    sel = P_W'($signed(a)) <<< 1;
                3'd3:    sel = P_W'($signed(a3));
                3'd4:    sel = P_W'($signed(a)) <<< 2;
                default: sel = '0;
            endcase
            if (dig.neg) begin
                sel = -sel;
            end
            pp_c[i] = P_W'(sel << (3*i));
        end
    end

    // Stage-2 partial product registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pp <= '0;
        end else begin
            pp <= pp_c;
        end
    end

endmodule

// File: rtl/unsigned8_mul.sv
// Pipelined signed 8x8 radix-8 Booth multiplier, weight-stationary A shared by B_NUM lanes.
// Optional simulation self-check enabled by defining UNSIGNED8_MUL_CHECK_EN.
module unsigned8_mul
    import unsigned8_mul_pkg::*;
#(
    parameter int unsigned B_NUM = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iAEn,
    input  logic [A_W-1:0]          iA,
    input  logic [A_W*B_NUM-1:0]    iB,
    output logic [P_W*B_NUM-1:0]    oRslt
);

    logic [A_W-1:0]                          a_q;
    logic [A_W*B_NUM-1:0]                    b_q;
    logic signed [A3_W-1:0]                  a3;
    logic [B_NUM-1:0][PP_NUM-1:0][P_W-1:0]   pp_lane;
    logic [B_NUM-1:0][P_W-1:0]               sum_c;
    logic [B_NUM-1:0][P_W-1:0]               sum_q;

    // Stage 1: A loads only when enabled, B streams every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (iAEn) begin
                a_q <= iA;
            end
            b_q <= iB;
        end
    end

    // Shared 3A, wide enough for -384..381
    assign a3 = A3_W'($signed(a_q)) + (A3_W'($signed(a_q)) <<< 1);

    for (genvar k = 0; k < B_NUM; k++) begin : g_lane
        unsigned8_mul_pp u_pp (
            .clk (clk),
            .rst (rst),
            .a   (a_q),
            .a3  (a3),
            .b   (b_q[A_W*k +: A_W]),
            .pp  (pp_lane[k])
        );
    end

    // Per-lane sum of partial products, truncated to the product width
    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < B_NUM; k++) begin
            for (int unsigned i = 0; i < PP_NUM; i++) begin
                sum_c[k] = sum_c[k] + pp_lane[k][i];
            end
        end
    end

    // Stage 3: registered products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_c;
        end
    end

    assign oRslt = sum_q;

`ifdef UNSIGNED8_MUL_CHECK_EN
    logic signed [P_W-1:0] chk_p1 [B_NUM];
    logic signed [P_W-1:0] chk_p2 [B_NUM];
    logic [A_W-1:0]        chk_a1, chk_a2;
    logic [A_W-1:0]        chk_b1 [B_NUM];
    logic [A_W-1:0]        chk_b2 [B_NUM];

    // Behavioural product delayed alongside the Booth pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_a1 <= '0;
            chk_a2 <= '0;
            for (int unsigned k = 0; k < B_NUM; k++) begin
                chk_p1[k] <= '0;
                chk_p2[k] <= '0;
                chk_b1[k] <= '0;
                chk_b2[k] <= '0;
            end
        end else begin
            chk_a1 <= a_q;
            chk_a2 <= chk_a1;
            for (int unsigned k = 0; k < B_NUM; k++) begin
                chk_p1[k] <= P_W'($signed(a_q) * $signed(b_q[A_W*k +: A_W]));
                chk_p2[k] <= chk_p1[k];
                chk_b1[k] <= b_q[A_W*k +: A_W];
                chk_b2[k] <= chk_b1[k];
            end
        end
    end

    // Compare away from the active edge once out of reset
    always @(negedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < B_NUM; k++) begin
                if (sum_q[k] !== chk_p2[k]) begin
                    $error("unsigned8_mul lane %0d: A=%0d B=%0d booth=%0d model=%0d", k,
                           $signed(chk_a2), $signed(chk_b2[k]), $signed(sum_q[k]), chk_p2[k]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_unsigned8_mul.sv
// Self-checking bench for unsigned8_mul: fixed corner vectors plus a delayed-product reference model.
module tb_unsigned8_mul;

    localparam int LANES = 2;
    typedef logic [LANES-1:0][15:0] prod_t;

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b1;
    logic                 a_en = 1'b0;
    logic [7:0]           a_in = '0;
    logic [8*LANES-1:0]   b_in = '0;
    logic [16*LANES-1:0]  rslt;

    int    n_cmp = 0;
    int    n_err = 0;
    int    a_m   = 0;
    prod_t hist[$];

    always #5 clk = ~clk;

    unsigned8_mul #(.B_NUM(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .iAEn  (a_en),
        .iA    (a_in),
        .iB    (b_in),
        .oRslt (rslt)
    );

    // Reference: product of the operands seen at each edge, visible two edges later
    always @(posedge clk or negedge rst) begin
        prod_t p;
        if (!rst) begin
            a_m  = 0;
            hist = {prod_t'('0), prod_t'('0), prod_t'('0)};
        end else begin
            if (a_en) a_m = int'($signed(a_in));
            for (int k = 0; k < LANES; k++)
                p[k] = 16'(a_m * int'($signed(b_in[8*k +: 8])));
            hist.push_front(p);
            void'(hist.pop_back());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int a, input bit en, input int b0);
        a_in = 8'(a);
        a_en = en;
        b_in[7:0] = 8'(b0);
        for (int k = 1; k < LANES; k++) b_in[8*k +: 8] = 8'($urandom);
    endtask

    task automatic test_reset();
        set_in(5, 1'b1, 7);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (rslt !== '0) begin
            $display("FAIL reset_async: got %h want 0", rslt); n_err++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rslt !== '0) begin
                $display("FAIL reset_hold%0d: got %h want 0", i, rslt); n_err++;
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rslt[15:0] !== 16'h0000) begin
                $display("FAIL reset_fill%0d: got %h want 0000", i, rslt[15:0]); n_err++;
            end
        end
        tick();
        n_cmp++;
        if (rslt[15:0] !== 16'h0023) begin
            $display("FAIL reset_first: got %h want 0023", rslt[15:0]); n_err++;
        end
    endtask

    task automatic test_signed_max();
        set_in(-127, 1'b1, -127);
        repeat (3) tick();
        n_cmp++;
        if (rslt[15:0] !== 16'h3F01) begin
            $display("FAIL neg_neg: got %h want 3f01", rslt[15:0]); n_err++;
        end
        set_in(127, 1'b1, -127);
        repeat (3) tick();
        n_cmp++;
        if (rslt[15:0] !== 16'hC0FF) begin
            $display("FAIL pos_neg: got %h want c0ff", rslt[15:0]); n_err++;
        end
    endtask

    task automatic test_corners();
        int         ca [4] = '{-128, -128, 0, 1};
        int         cb [4] = '{-128, 127, -128, -1};
        logic [15:0] ce [4] = '{16'h4000, 16'hC080, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            set_in(ca[i], 1'b1, cb[i]);
            repeat (3) tick();
            n_cmp++;
            if (rslt[15:0] !== ce[i]) begin
                $display("FAIL corner%0d: got %h want %h", i, rslt[15:0], ce[i]); n_err++;
            end
            n_cmp++;
            if (rslt !== hist[2]) begin
                $display("FAIL corner%0d_lanes: got %h want %h", i, rslt, hist[2]); n_err++;
            end
        end
    endtask

    task automatic test_sweep();
        int bad = 0;
        for (int a = -127; a <= 127; a++) begin
            for (int b = -127; b <= 127; b++) begin
                set_in(a, 1'b1, b);
                tick();
                n_cmp++;
                if (rslt !== hist[2]) begin
                    bad++;
                    n_err++;
                    if (bad <= 10)
                        $display("FAIL sweep a=%0d b=%0d: got %h want %h", a, b, rslt, hist[2]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        int fe [5] = '{-6, -3, 0, 3, 6};
        set_in(3, 1'b1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(100, 1'b0, i - 2);
            repeat (3) tick();
            n_cmp++;
            if (rslt[15:0] !== 16'(fe[i])) begin
                $display("FAIL freeze b=%0d: got %h want %h", i - 2, rslt[15:0], 16'(fe[i])); n_err++;
            end
        end
    endtask

    task automatic test_back_to_back(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            set_in(int'($urandom_range(255)), 1'($urandom), int'($urandom_range(255)));
            tick();
            n_cmp++;
            if (rslt !== hist[2]) begin
                $display("FAIL %s cyc%0d: got %h want %h", tag, i, rslt, hist[2]); n_err++;
            end
        end
    endtask

    task automatic test_reset_mid();
        test_back_to_back(20, "pre_rst");
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (rslt !== '0) begin
            $display("FAIL mid_rst_async: got %h want 0", rslt); n_err++;
        end
        tick();
        n_cmp++;
        if (rslt !== '0) begin
            $display("FAIL mid_rst_hold: got %h want 0", rslt); n_err++;
        end
        rst = 1'b1;
        set_in(-7, 1'b1, 9);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rslt[15:0] !== 16'h0000) begin
                $display("FAIL mid_rst_fill%0d: got %h want 0000", i, rslt[15:0]); n_err++;
            end
        end
        tick();
        n_cmp++;
        if (rslt[15:0] !== 16'hFFC1) begin
            $display("FAIL mid_rst_resume: got %h want ffc1", rslt[15:0]); n_err++;
        end
        test_back_to_back(20, "post_rst");
    endtask

    initial begin
        hist = {prod_t'('0), prod_t'('0), prod_t'('0)};
        test_reset();
        test_signed_max();
        test_corners();
        test_freeze();
        test_back_to_back(500, "stream");
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
